// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file: RV32I integer register file, 32 x 32-bit.
//
// Sits between decode (which supplies rs1/rs2/rd) and the ALU/writeback path
// of the single-cycle core. Two combinational read ports, one synchronous
// write port. Register x0 is hard-wired to zero.
//
// Ports:
//   clk    in   1           core clock; writes commit on the rising edge
//   rst_n  in   1           asynchronous active-low reset; clears all regs
//   ra1    in   ADDR_WIDTH  read address, port 1 (rs1)
//   ra2    in   ADDR_WIDTH  read address, port 2 (rs2)
//   rd1    out  DATA_WIDTH  read data, port 1
//   rd2    out  DATA_WIDTH  read data, port 2
//   write  in   1           write enable, sampled at rising clk
//   wa     in   ADDR_WIDTH  write address (rd)
//   wd     in   DATA_WIDTH  write data
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a pending write (write=1, wa!=0) is
//                      forwarded combinationally to any read port whose
//                      address matches wa, so the new value is visible in
//                      the same cycle, before the committing edge. When not
//                      defined, reads show only committed contents.
//
// There is no handshake on this block: a write is a single-cycle command
// qualified only by 'write'; reads have zero-cycle latency.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Entry 0 exists so every address indexes in range, but it is only ever
  // loaded with zero by reset and the read path masks it anyway.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // A write is effective only when enabled and not targeting x0.
  logic wr_en;
  assign wr_en = write && (wa != '0);

  // -------------------------------------------------------------------------
  // Storage. Reset is asynchronous, so an edge that coincides with an active
  // reset never commits a write: reset wins.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports. Purely combinational; reading never touches state, so X on
  // an address can only produce X data, never corrupt storage.
  // -------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed while reset is held so that every read returns
  // zero during reset regardless of what is on the write port.
  logic fwd1;
  logic fwd2;
  assign fwd1 = rst_n && wr_en && (ra1 == wa);
  assign fwd2 = rst_n && wr_en && (ra2 == wa);

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = fwd1 ? wd : regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      rd2 = fwd2 ? wd : regs[ra2];
    end
  end
`else
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      rd2 = regs[ra2];
    end
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file: directed, self-checking bench for reg_file.
// Inputs change 1 ns after a rising edge; outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ROUNDS = 1000;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          write;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  int errors = 0;
  int checks = 0;

  // Reference contents of x0..x31 for the random sweep.
  logic [DW-1:0] model [32];

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .write (write),
    .wa    (wa),
    .wd    (wd)
  );

  // -------------------------------------------------------------------------
  // Clock: 10 ns period.
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Driver helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = 1'b1;
    wa    = a;
    wd    = d;
    tick();
    write = 1'b0;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] v;
    int            port;

    rst_n = 1'b0;
    write = 1'b0;
    wa    = '0;
    wd    = '0;
    ra1   = 5'd5;
    ra2   = 5'd31;
    void'($urandom(32'h00C0FFEE));

    // Reset state: everything reads zero.
    #3;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);

    // Release mid-cycle; first write lands on the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    do_write(5'd5, 32'hDEADBEEF);
    ra1 = 5'd5;
    #1;
    check("x5_written", rd1, 32'hDEADBEEF);

    // Asynchronous reset mid-cycle (now ~posedge+2, next edge at +5).
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_x5", rd1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // x0 is hard-wired: the all-ones write is discarded.
    do_write(5'd0, 32'hFFFFFFFF);
    ra1 = 5'd0;
    ra2 = 5'd0;
    #1;
    check("x0_rd1", rd1, 32'h0);
    check("x0_rd2", rd2, 32'h0);

    // Write-enable gating: three disabled cycles with new data on wa=7.
    do_write(5'd7, 32'h12345678);
    write = 1'b0;
    wa    = 5'd7;
    wd    = 32'hAAAAAAAA;
    tick();
    tick();
    tick();
    ra2 = 5'd7;
    #1;
    check("we_gate_x7", rd2, 32'h12345678);

    // Dual-port concurrent reads, then swapped addresses.
    do_write(5'd3, 32'h11111111);
    do_write(5'd4, 32'h22222222);
    ra1 = 5'd3;
    ra2 = 5'd4;
    #1;
    check("dual_rd1_x3", rd1, 32'h11111111);
    check("dual_rd2_x4", rd2, 32'h22222222);
    ra1 = 5'd4;
    ra2 = 5'd3;
    #1;
    check("swap_rd1_x4", rd1, 32'h22222222);
    check("swap_rd2_x3", rd2, 32'h11111111);

    // Both ports on the same register.
    ra1 = 5'd7;
    ra2 = 5'd7;
    #1;
    check("same_rd1_x7", rd1, 32'h12345678);
    check("same_rd2_x7", rd2, 32'h12345678);

    // Read-during-write on x9.
    do_write(5'd9, 32'h00000001);
    write = 1'b1;
    wa    = 5'd9;
    wd    = 32'h00000002;
    ra1   = 5'd9;
    ra2   = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_before_edge", rd1, 32'h00000002);
`else
    check("rdw_before_edge", rd1, 32'h00000001);
`endif
    check("rdw_other_port", rd2, 32'h11111111);
    tick();
    write = 1'b0;
    #1;
    check("rdw_after_edge", rd1, 32'h00000002);

    // Pending write to x0 never shows on an x0 read, in either build.
    write = 1'b1;
    wa    = 5'd0;
    wd    = 32'h5A5A5A5A;
    ra1   = 5'd0;
    #1;
    check("x0_pending_write", rd1, 32'h0);
    tick();
    write = 1'b0;
    #1;
    check("x0_after_write", rd1, 32'h0);

    // Reset asserted while a write to x10 is presented across an edge.
    do_write(5'd10, 32'h0BADF00D);
    write = 1'b1;
    wa    = 5'd10;
    wd    = 32'h00000055;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    write = 1'b0;
    ra1   = 5'd10;
    ra2   = 5'd9;
    #1;
    check("reset_wins_x10", rd1, 32'h0);
    check("reset_clears_x9", rd2, 32'h0);
    tick();

    // Random sweep: fill x1..x31 each round, then read every register
    // back through a randomly chosen port.
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      for (int i = 1; i < 32; i++) begin
        v = $urandom();
        model[i] = v;
        do_write(AW'(i), v);
      end
      for (int i = 1; i < 32; i++) begin
        port = $urandom_range(0, 1);
        if (port == 0) begin
          ra1 = AW'(i);
          #1;
          check("sweep_rd1", rd1, model[i]);
        end else begin
          ra2 = AW'(i);
          #1;
          check("sweep_rd2", rd2, model[i]);
        end
      end
    end

    // Persistence: values survive idle cycles with write=0.
    wa = 5'd31;
    wd = ~model[31];
    tick();
    tick();
    ra1 = 5'd31;
    ra2 = 5'd1;
    #1;
    check("persist_x31", rd1, model[31]);
    check("persist_x1", rd2, model[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- RV32I single-cycle integer register file: 32 x 32-bit general-purpose registers.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Register x0 is hard-wired to zero.
- Sits between decode, which supplies rs1/rs2/rd, and the ALU/writeback path in the single-cycle core.

Parameters:
- DATA_WIDTH, 32, width of each register and of the rd1/rd2/wd data paths.
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  core clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all registers.
- ra1  input  ADDR_WIDTH  read address, port 1 (rs1).
- ra2  input  ADDR_WIDTH  read address, port 2 (rs2).
- rd1  output  DATA_WIDTH  read data, port 1.
- rd2  output  DATA_WIDTH  read data, port 2.
- write  input  1  write enable, sampled at rising clk.
- wa  input  ADDR_WIDTH  write address (rd).
- wd  input  DATA_WIDTH  write data.
- Clocking/reset: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: rst_n low immediately clears registers 1..31 to 0, independent of clk. rd1/rd2 therefore read 0 for every address while reset is held.
- Reset release: rst_n deassertion is asynchronous. The first write can occur on the first rising clk edge at which rst_n is high.
- Write: at rising clk, if rst_n=1, write=1 and wa!=0, then reg[wa] <= wd. Otherwise there is no state change.
- Writes with wa=0 are discarded.
- Writes with write=0 are ignored regardless of wa/wd values.
- Read: rd1 = (ra1==0) ? 0 : reg[ra1], and rd2 likewise from ra2.
- Reads are purely combinational, with zero-cycle latency from the address change.
- A newly written value is visible on rd1/rd2 immediately after the rising edge that commits it. A read issued on any later cycle returns the written value.
- Both ports may address the same register simultaneously; both return identical data.
- Read-during-write to the same address (no bypass, see Optional Feature): rd returns the old value until the edge, then the new value.
- Register values persist indefinitely with write=0. There is no other clearing mechanism besides rst_n.
- Reset asserted mid-write: reset wins; the register ends at 0.
- Unknown/X inputs on ra1/ra2 must not corrupt stored state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: internal write-to-read forwarding. Forwarding applies when write=1, wa!=0 and ra1==wa (or ra2==wa); the corresponding rd output combinationally returns wd in the same cycle, before the edge. x0 reads remain 0 even when wa=0 with write=1.
- Not defined: no forwarding. Reads reflect only committed register contents.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing 0xDEADBEEF to x5 -> rd1 with ra1=5 reads 0 immediately, without waiting for a clk edge.
- x0 hard-wired: write=1, wa=0, wd=0xFFFFFFFF, one clock, then ra1=0 and ra2=0 -> rd1=rd2=0.
- Full sweep, 1000 rounds with a seeded random stream: for i=1..31, write a random value to xi on one edge, deassert write, then read xi from a randomly chosen port on a later cycle -> exact match. Any mismatch fails the test.
- Write-enable gating: x7=0x12345678, then drive write=0, wa=7, wd=0xAAAAAAAA for 3 cycles -> rd2 with ra2=7 still reads 0x12345678.
- Dual-port concurrent: x3=0x11111111, x4=0x22222222, then ra1=3, ra2=4 in the same cycle -> rd1=0x11111111, rd2=0x22222222. Swapping the addresses swaps the outputs.
- Read-during-write: x9=0x1, then write=1, wa=9, wd=0x2 with ra1=9 before the edge -> rd1=0x1 without REGFILE_BYPASS_EN, or 0x2 with it. After the edge, rd1=0x2 in both builds.
